ahblite_bram_ctrl: RTL and testbench
====================================

AHBLITE_BRAM_CTRL -- requirements
Module: ahblite_bram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, giving the BRAM word-address width (BRAM holds 2**ADDR_WIDTH 32-bit words).
REQ-002 SHALL have port HCLK  input  1  sole clock; every register updates on its rising edge.
REQ-003 SHALL have port HRESETn  input  1  reset; synchronous and active-low.
REQ-004 SHALL have ports HSEL in 1, HADDR in 32, HTRANS in 2, HSIZE in 3, HPROT in 4 (ignored), HWRITE in 1, HWDATA in 32, HREADY in 1: AHB-Lite slave inputs.
REQ-005 SHALL have ports HREADYOUT out 1, HRDATA out 32, HRESP out 1: AHB-Lite slave outputs.
REQ-006 SHALL have ports BRAM_RDADDR out ADDR_WIDTH, BRAM_WRADDR out ADDR_WIDTH, BRAM_WDATA out 32, BRAM_WE out 4: drive the downstream dual-port BRAM.
REQ-007 SHALL have port BRAM_RDATA in 32: registered BRAM read data, valid one cycle after BRAM_RDADDR.

Function
REQ-008 Transfer accepted SHALL mean HSEL & HTRANS[1] & HREADY at a rising edge; IDLE/BUSY transfers and unselected cycles SHALL have no effect.
REQ-009 HRESP SHALL be constant 0 (OKAY).
REQ-010 Word address SHALL be HADDR[ADDR_WIDTH+1:2]; HADDR bits above ADDR_WIDTH+1 SHALL be ignored.
REQ-011 Byte lanes: HSIZE 0 -> 4'b0001 << HADDR[1:0]; HSIZE 1 -> 4'b0011 if HADDR[1]=0, else 4'b1100; HSIZE >= 2 -> 4'b1111.
REQ-012 On an accepted write: word address and lane mask SHALL be registered; in the following data-phase cycle BRAM_WE = mask, BRAM_WRADDR = registered address, BRAM_WDATA = HWDATA. At all other times BRAM_WE SHALL be 4'b0000.
REQ-013 Outside RD_STALL, BRAM_RDADDR SHALL equal the HADDR word address combinationally, so read data appears on BRAM_RDATA in the data phase with zero wait states.
REQ-014 State machine SHALL have states IDLE, WR_DATA, RD_DATA and RD_STALL.
- Accepted write -> WR_DATA.
- Accepted read -> RD_DATA.
- No accepted transfer, or HREADY low -> IDLE.
- RD_STALL -> RD_DATA after exactly one cycle.
REQ-015 Hazard SHALL mean a read is accepted while in WR_DATA with the same word address as the pending write (the BRAM returns pre-write data).
REQ-016 HRDATA SHALL equal BRAM_RDATA except where modified by the hazard handling in REQ-021/REQ-022.
REQ-017 HREADYOUT SHALL be 1 in every state except RD_STALL, where it SHALL be 0.
REQ-018 Back-to-back writes, and writes to different words, SHALL complete with zero wait states.

Reset
REQ-019 When HRESETn is low at a rising edge, the following SHALL hold from the next cycle:
- state = IDLE, BRAM_WE = 0, HREADYOUT = 1;
- registered address, mask and forwarding registers = 0.
REQ-020 A reset asserted mid-write SHALL suppress that write. A reset asserted in RD_STALL SHALL abort the stall.

Configuration
REQ-021 With macro BRAM_WR_FWD_EN defined, on a hazard:
- registered write data and mask SHALL be merged per byte into HRDATA in the read data phase (written lanes from write data, others from BRAM_RDATA);
- RD_STALL SHALL never be entered.
REQ-022 With BRAM_WR_FWD_EN undefined, on a hazard:
- the read data phase SHALL enter RD_STALL;
- BRAM_RDADDR SHALL be the registered read address during RD_STALL;
- HRDATA SHALL be taken from BRAM_RDATA in the following RD_DATA cycle, giving one wait state.

Structure
REQ-023 Package ahblite_bram_pkg SHALL hold the HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), the HSIZE encodings and the state enum.
REQ-024 Lane decode (REQ-011) SHALL be sub-module ahblite_bram_bytemask, which is purely combinational; the remainder stays in one module.

Verification
REQ-025 Reset: HRESETn=0 for 2 cycles -> HREADYOUT=1, BRAM_WE=0, HRESP=0.
REQ-026 Word write 0x20 (HWDATA 0xDEADBEEF) followed by read 0x24 -> BRAM_WE=4'b1111, BRAM_WRADDR=8 in the write data phase; read completes with no wait state.
REQ-027 Byte write HSIZE=0 to 0x13 (HWDATA 0xAB000000) -> BRAM_WE=4'b1000, BRAM_WRADDR=4. Halfword write to 0x12 -> BRAM_WE=4'b1100.
REQ-028 Hazard, word 0x40 preloaded with 0x11223344, then halfword write of 0xBEEF to 0x40 immediately followed by a read of 0x40:
- with BRAM_WR_FWD_EN: HRDATA=0x1122BEEF, no wait state;
- without it: one HREADYOUT=0 cycle, then HRDATA=0x1122BEEF.
REQ-029 HTRANS=BUSY, or HSEL=0 with HTRANS=NONSEQ and HWRITE=1 -> BRAM_WE stays 0 and state stays IDLE.
REQ-030 HRESETn pulled low in a write data phase -> BRAM_WE=0 next cycle and memory unchanged.

Source files
------------

// File: rtl/ahblite_bram_pkg.sv
// Shared definitions for the AHB-Lite to dual-port BRAM controller:
// AHB transfer/size encodings, controller state type and byte-lane merge helper.
package ahblite_bram_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'b000,
      HSIZE_HALF  = 3'b001,
      HSIZE_WORD  = 3'b010,
      HSIZE_DWORD = 3'b011
   } hsize_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WR_DATA  = 2'd1,
      ST_RD_DATA  = 2'd2,
      ST_RD_STALL = 2'd3
   } state_t;

   // Per-byte select: lanes set in i_mask come from i_new, the rest from i_old.
   function automatic logic [31:0] merge_lanes(input logic [31:0] i_new,
                                               input logic [31:0] i_old,
                                               input logic [3:0]  i_mask);
      logic [31:0] v_res;
      v_res = i_old;
      for (int unsigned b = 0; b < 4; b++) begin
         if (i_mask[b]) v_res[8*b +: 8] = i_new[8*b +: 8];
      end
      return v_res;
   endfunction

endpackage

// File: rtl/ahblite_bram_bytemask.sv
// Byte-lane decode for an AHB-Lite transfer: HSIZE plus the low address bits
// give the 4-bit write-enable mask. Purely combinational.
module ahblite_bram_bytemask
   import ahblite_bram_pkg::*;
(
   input  logic [2:0] i_hsize,
   input  logic [1:0] i_addr_lo,
   output logic [3:0] o_mask
);

   // Decode transfer size and alignment into active byte lanes
   always_comb begin
      o_mask = '0;
      case (i_hsize)
         HSIZE_BYTE: o_mask = 4'b0001 << i_addr_lo;
         HSIZE_HALF: o_mask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
         default:    o_mask = '1;
      endcase
   end

endmodule

// File: rtl/ahblite_bram_ctrl.sv
// AHB-Lite slave fronting a dual-port BRAM with registered read data.
// Reads are zero-wait (read address driven straight from HADDR); writes are
// registered and committed in the data phase. A read of the word being written
// in the previous cycle is a hazard, resolved by one of two builds:
//   BRAM_WR_FWD_EN defined   : merge pending write data into HRDATA, no stall.
//   BRAM_WR_FWD_EN undefined : insert one RD_STALL wait state and re-read.
module ahblite_bram_ctrl
   import ahblite_bram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 14
)(
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic [3:0]            HPROT,
   input  logic                  HWRITE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic [31:0]           HRDATA,
   output logic                  HRESP,
   output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
   output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
   output logic [31:0]           BRAM_WDATA,
   output logic [3:0]            BRAM_WE,
   input  logic [31:0]           BRAM_RDATA
);

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_accept;
   logic                  w_wr_accept;
   logic                  w_rd_accept;
   logic                  w_hazard;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [3:0]            w_mask;
   logic [3:0]            r_wr_mask;
   logic                  w_unused;

   assign w_accept    = HSEL & HTRANS[1] & HREADY;
   assign w_wr_accept = w_accept & HWRITE;
   assign w_rd_accept = w_accept & ~HWRITE;
   assign w_addr      = HADDR[ADDR_WIDTH+1:2];
   assign w_hazard    = w_rd_accept & (r_state == ST_WR_DATA) & (w_addr == r_wr_addr);
   assign w_unused    = ^{HPROT, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

   assign HRESP       = 1'b0;
   assign BRAM_WRADDR = r_wr_addr;
   assign BRAM_WDATA  = HWDATA;

   ahblite_bram_bytemask u_bytemask (
      .i_hsize   (HSIZE),
      .i_addr_lo (HADDR[1:0]),
      .o_mask    (w_mask)
   );

   // State register
   always_ff @(posedge HCLK) begin
      if (!HRESETn) r_state <= ST_IDLE;
      else          r_state <= w_next_state;
   end

   // Next-state decode: stall lasts one cycle, otherwise follow the accepted transfer
   always_comb begin
      w_next_state = ST_IDLE;
      if (r_state == ST_RD_STALL) begin
         w_next_state = ST_RD_DATA;
      end else if (w_wr_accept) begin
         w_next_state = ST_WR_DATA;
      end else if (w_rd_accept) begin
`ifdef BRAM_WR_FWD_EN
         w_next_state = ST_RD_DATA;
`else
         w_next_state = w_hazard ? ST_RD_STALL : ST_RD_DATA;
`endif
      end
   end

   // Capture address-phase information for the following data phase
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_wr_addr <= '0;
         r_wr_mask <= '0;
         r_rd_addr <= '0;
      end else begin
         if (w_wr_accept) begin
            r_wr_addr <= w_addr;
            r_wr_mask <= w_mask;
         end
         if (w_rd_accept) r_rd_addr <= w_addr;
      end
   end

`ifdef BRAM_WR_FWD_EN
   logic        r_fwd_hit;
   logic [3:0]  r_fwd_mask;
   logic [31:0] r_fwd_data;

   // Hold the colliding write's data and lanes for the read data phase
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_fwd_hit  <= 1'b0;
         r_fwd_mask <= '0;
         r_fwd_data <= '0;
      end else begin
         r_fwd_hit <= w_hazard;
         if (w_hazard) begin
            r_fwd_mask <= r_wr_mask;
            r_fwd_data <= HWDATA;
         end
      end
   end
`endif

   // Outputs per state; write enable is dropped while reset is held so a
   // reset arriving in the write data phase blocks the commit at that edge
   always_comb begin
      HREADYOUT   = 1'b1;
      BRAM_WE     = '0;
      BRAM_RDADDR = w_addr;
      HRDATA      = BRAM_RDATA;
      case (r_state)
         ST_WR_DATA:  if (HRESETn) BRAM_WE = r_wr_mask;
         ST_RD_STALL: begin
            HREADYOUT   = 1'b0;
            BRAM_RDADDR = r_rd_addr;
         end
         default: ;
      endcase
`ifdef BRAM_WR_FWD_EN
      if (r_fwd_hit) HRDATA = merge_lanes(r_fwd_data, BRAM_RDATA, r_fwd_mask);
`endif
   end

endmodule

// File: tb/tb_ahblite_bram_ctrl.sv
// Self-checking bench for ahblite_bram_ctrl (default build or BRAM_WR_FWD_EN).
// A bus driver pipelines AHB-Lite transfers; a shadow memory of bytes predicts
// read data, lane masks and hazard wait states.
module tb_ahblite_bram_ctrl;
   import ahblite_bram_pkg::*;

   localparam int unsigned AW    = 14;
   localparam int unsigned DEPTH = 1 << AW;
`ifdef BRAM_WR_FWD_EN
   localparam int unsigned HZW = 0;
`else
   localparam int unsigned HZW = 1;
`endif

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          HSEL;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic [2:0]    HSIZE;
   logic [3:0]    HPROT;
   logic          HWRITE;
   logic [31:0]   HWDATA;
   logic          HREADY;
   logic          HREADYOUT;
   logic [31:0]   HRDATA;
   logic          HRESP;
   logic [AW-1:0] BRAM_RDADDR;
   logic [AW-1:0] BRAM_WRADDR;
   logic [31:0]   BRAM_WDATA;
   logic [3:0]    BRAM_WE;
   logic [31:0]   BRAM_RDATA = '0;
   logic          hready_en;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 HCLK = ~HCLK;
   assign HREADY = HREADYOUT & hready_en;

   ahblite_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
      .BRAM_RDADDR(BRAM_RDADDR), .BRAM_WRADDR(BRAM_WRADDR), .BRAM_WDATA(BRAM_WDATA),
      .BRAM_WE(BRAM_WE), .BRAM_RDATA(BRAM_RDATA)
   );

   // Read-first dual-port BRAM with one-cycle registered read
   logic [31:0] bram [0:DEPTH-1] = '{default: '0};
   always @(posedge HCLK) begin
      for (int b = 0; b < 4; b++)
         if (BRAM_WE[b]) bram[BRAM_WRADDR][8*b +: 8] <= BRAM_WDATA[8*b +: 8];
      BRAM_RDATA <= bram[BRAM_RDADDR];
   end

   // Reference model state
   logic [31:0]   ref_mem [0:DEPTH-1] = '{default: '0};
   logic          dp_valid = 1'b0;
   logic          dp_write = 1'b0;
   logic [31:0]   dp_addr  = '0;
   logic [2:0]    dp_size  = '0;
   logic [31:0]   dp_wdata = '0;
   int unsigned   dp_exp_waits = 0;
   logic [3:0]    obs_we;
   logic [AW-1:0] obs_wraddr;
   logic [31:0]   obs_rdata;
   int unsigned   obs_waits;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] word_of(input logic [31:0] a);
      return a[AW+1:2];
   endfunction

   // Lanes from transfer byte count and naturally aligned offset
   function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] s);
      int unsigned nb, off, m;
      nb  = (s >= 3'd2) ? 4 : (1 << s);
      off = (int'(a[1:0]) / nb) * nb;
      m   = ((1 << nb) - 1) << off;
      return m[3:0];
   endfunction

   // One address phase; completes the previous data phase and models it
   task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
      int unsigned waits;
      logic done, ready, acc, hz;
      logic [3:0] lm;
      HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
      HWDATA = dp_wdata;
      waits = 0;
      done  = 1'b0;
      while (!done) begin
         @(negedge HCLK);
         chk("hresp", 32'(HRESP), 32'h0);
         if (dp_valid && dp_write) begin
            chk("wr_we", 32'(BRAM_WE), 32'(lanes(dp_addr, dp_size)));
            chk("wr_addr", 32'(BRAM_WRADDR), 32'(word_of(dp_addr)));
         end else begin
            chk("we_idle", 32'(BRAM_WE), 32'h0);
         end
         ready = HREADYOUT;
         if (ready) begin
            if (dp_valid && !dp_write) begin
               chk("rd_data", HRDATA, ref_mem[word_of(dp_addr)]);
               chk("rd_waits", waits, dp_exp_waits);
            end
            obs_we = BRAM_WE; obs_wraddr = BRAM_WRADDR; obs_rdata = HRDATA; obs_waits = waits;
         end
         @(posedge HCLK);
         if (ready) begin
            acc = sel && trans[1] && hready_en;
            hz  = acc && !wr && dp_valid && dp_write && (word_of(dp_addr) == word_of(addr));
            if (dp_valid && dp_write) begin
               lm = lanes(dp_addr, dp_size);
               for (int b = 0; b < 4; b++)
                  if (lm[b]) ref_mem[word_of(dp_addr)][8*b +: 8] = dp_wdata[8*b +: 8];
            end
            dp_valid = acc; dp_write = wr; dp_addr = addr; dp_size = size; dp_wdata = wdata;
            dp_exp_waits = hz ? HZW : 0;
            done = 1'b1;
         end else begin
            waits++;
            if (waits > 4) begin
               checks++; errors++;
               $display("FAIL stall_timeout actual=%0d required<=%0d", waits, HZW);
               dp_valid = 1'b0;
               done = 1'b1;
            end
         end
      end
      #1;
   endtask

   typedef struct {
      logic          wr;
      logic [31:0]   addr;
      logic [2:0]    size;
      logic [31:0]   wdata;
      logic [3:0]    exp_we;
      logic [AW-1:0] exp_wraddr;
      logic [31:0]   exp_rdata;
      int unsigned   exp_waits;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   task automatic check_vec(input int k);
      if (vecs[k].wr) begin
         chk($sformatf("vec%0d_we", k), 32'(obs_we), 32'(vecs[k].exp_we));
         chk($sformatf("vec%0d_wraddr", k), 32'(obs_wraddr), 32'(vecs[k].exp_wraddr));
      end else begin
         chk($sformatf("vec%0d_rdata", k), obs_rdata, vecs[k].exp_rdata);
         chk($sformatf("vec%0d_waits", k), obs_waits, vecs[k].exp_waits);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h0000_0020, 3'd2, 32'hDEAD_BEEF, 4'b1111, 14'h08, 32'h0, 0};
      vecs[1]  = '{1'b0, 32'h0000_0024, 3'd2, 32'h0,         4'b0000, 14'h00, 32'h0, 0};
      vecs[2]  = '{1'b0, 32'h0000_0020, 3'd2, 32'h0,         4'b0000, 14'h00, 32'hDEAD_BEEF, 0};
      vecs[3]  = '{1'b1, 32'h0000_0013, 3'd0, 32'hAB00_0000, 4'b1000, 14'h04, 32'h0, 0};
      vecs[4]  = '{1'b1, 32'h0000_0012, 3'd1, 32'hCDEF_0000, 4'b1100, 14'h04, 32'h0, 0};
      vecs[5]  = '{1'b0, 32'h0000_0010, 3'd2, 32'h0,         4'b0000, 14'h00, 32'hCDEF_0000, HZW};
      vecs[6]  = '{1'b1, 32'h0000_0040, 3'd2, 32'h1122_3344, 4'b1111, 14'h10, 32'h0, 0};
      vecs[7]  = '{1'b1, 32'h0000_0040, 3'd1, 32'h0000_BEEF, 4'b0011, 14'h10, 32'h0, 0};
      vecs[8]  = '{1'b0, 32'h0000_0040, 3'd2, 32'h0,         4'b0000, 14'h00, 32'h1122_BEEF, HZW};
      vecs[9]  = '{1'b1, 32'h0000_0041, 3'd0, 32'h0000_5500, 4'b0010, 14'h10, 32'h0, 0};
      vecs[10] = '{1'b0, 32'h0000_0044, 3'd2, 32'h0,         4'b0000, 14'h00, 32'h0, 0};
      vecs[11] = '{1'b0, 32'h0000_0040, 3'd2, 32'h0,         4'b0000, 14'h00, 32'h1122_55EF, 0};
      vecs[12] = '{1'b1, 32'hFFFF_0050, 3'd2, 32'h1234_5678, 4'b1111, 14'h14, 32'h0, 0};
      vecs[13] = '{1'b0, 32'h0000_0050, 3'd2, 32'h0,         4'b0000, 14'h00, 32'h1234_5678, HZW};
      vecs[14] = '{1'b1, 32'h0000_0060, 3'd3, 32'h0BAD_F00D, 4'b1111, 14'h18, 32'h0, 0};

      HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HSIZE = '0;
      HPROT = 4'h3; HWRITE = 1'b0; HWDATA = '0; hready_en = 1'b1;

      // Reset held for two edges
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
      chk("rst_we", 32'(BRAM_WE), 32'h0);
      chk("rst_hresp", 32'(HRESP), 32'h0);
      HRESETn = 1'b1;

      // Directed table, back-to-back NONSEQ transfers
      for (int i = 0; i < NV; i++) begin
         issue(1'b1, HTRANS_NONSEQ, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata);
         if (i > 0) check_vec(i - 1);
      end
      issue(1'b0, HTRANS_IDLE, 1'b0, '0, '0, '0);
      check_vec(NV - 1);

      // BUSY and unselected writes are ignored
      issue(1'b1, HTRANS_BUSY,   1'b1, 32'h70, 3'd2, 32'hFFFF_FFFF);
      issue(1'b0, HTRANS_NONSEQ, 1'b1, 32'h74, 3'd2, 32'hFFFF_FFFF);
      issue(1'b0, HTRANS_IDLE,   1'b0, '0, '0, '0);
      chk("ignored_we", 32'(obs_we), 32'h0);
      issue(1'b1, HTRANS_NONSEQ, 1'b0, 32'h70, 3'd2, '0);
      issue(1'b1, HTRANS_NONSEQ, 1'b0, 32'h74, 3'd2, '0);
      issue(1'b0, HTRANS_IDLE,   1'b0, '0, '0, '0);
      chk("ignored_mem", obs_rdata, 32'h0);

      // NONSEQ write while HREADY is low is not accepted
      hready_en = 1'b0;
      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h78; HSIZE = 3'd2;
      @(posedge HCLK); #1;
      hready_en = 1'b1;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
      @(negedge HCLK);
      chk("hready_low_we", 32'(BRAM_WE), 32'h0);
      @(posedge HCLK); #1;

      // Reset during a write data phase suppresses the write
      issue(1'b1, HTRANS_NONSEQ, 1'b1, 32'h80, 3'd2, 32'hCAFE_F00D);
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = dp_wdata; HRESETn = 1'b0;
      @(negedge HCLK);
      chk("rstwr_we_now", 32'(BRAM_WE), 32'h0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      dp_valid = 1'b0;
      @(negedge HCLK);
      chk("rstwr_we_next", 32'(BRAM_WE), 32'h0);
      chk("rstwr_hreadyout", 32'(HREADYOUT), 32'h1);
      @(posedge HCLK); #1;
      issue(1'b1, HTRANS_NONSEQ, 1'b0, 32'h80, 3'd2, '0);
      issue(1'b0, HTRANS_IDLE,   1'b0, '0, '0, '0);
      chk("rstwr_mem", obs_rdata, 32'h0);

      // Randomized traffic over a few words to provoke read-after-write hazards
      for (int n = 0; n < 400; n++) begin
         int unsigned sz, nb, off, w, r;
         logic [1:0]  tr;
         logic [31:0] a;
         sz  = $urandom_range(0, 3);
         nb  = (sz >= 2) ? 4 : (1 << sz);
         off = ($urandom_range(0, 3) / nb) * nb;
         w   = 32'h100 + $urandom_range(0, 7);
         a   = ($urandom() << 16) | (w << 2) | off;
         r   = $urandom_range(0, 9);
         tr  = (r < 1) ? HTRANS_IDLE : (r < 2) ? HTRANS_BUSY : (r < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
         issue(($urandom_range(0, 99) < 88), tr, 1'($urandom_range(0, 1)), a, 3'(sz), $urandom());
      end
      issue(1'b0, HTRANS_IDLE, 1'b0, '0, '0, '0);
      issue(1'b0, HTRANS_IDLE, 1'b0, '0, '0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
